// File: rtl/instr_cycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] -> WB.
// Converts decoded control levels into single-cycle strobes and memory handshakes.
module instr_cycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                branch,
    input  logic                mem_rs,
    input  logic                mem_ws,
    input  logic                cntrl_rs,
    input  logic                alu_zero,
    output logic                imem_req,
    input  logic                imem_ack,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic                ir_load,
    output logic                rf_we,
    output logic                pc_we,
    output logic                pc_sel,
    output logic                busy,
    output logic                err,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam logic [7:0]          WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [RETIRE_W-1:0] RET_ONE   = RETIRE_W'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_wait;
    logic [7:0]            w_wait_next;
    logic                  r_take_branch;
    logic                  r_dmem_we;
    logic                  r_rf_we;
    logic                  r_err;
    logic [RETIRE_W-1:0]   r_retired;

    // Next-state logic; the wait counter is cleared on every entry into FETCH or MEM.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_next = S_FETCH;
                    w_wait_next  = 8'd0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_state_next = S_DECODE;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_next = S_ERROR;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                end
            end
            S_DECODE: begin
                w_state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (mem_rs && mem_ws) begin
                    w_state_next = S_ERROR;
                end else if (mem_rs || mem_ws) begin
                    w_state_next = S_MEM;
                    w_wait_next  = 8'd0;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                // An ack on the limit cycle still completes the access.
                if (dmem_ack) begin
                    w_state_next = S_WB;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_next = S_ERROR;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                end
            end
            S_WB: begin
                if (run) begin
                    w_state_next = S_FETCH;
                    w_wait_next  = 8'd0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ERROR: begin
                w_state_next = S_ERROR;
            end
            default: begin
                w_state_next = S_IDLE;
                w_wait_next  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wait        <= 8'd0;
            r_take_branch <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_rf_we       <= 1'b0;
            r_err         <= 1'b0;
            r_retired     <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (r_state == S_EXECUTE) begin
                r_take_branch <= branch & alu_zero;
                r_dmem_we     <= mem_ws;
            end
            // Register the write strobe so rf_we has no path from cntrl_rs.
            r_rf_we <= (w_state_next == S_WB) & cntrl_rs;
            if (w_state_next == S_ERROR) begin
                r_err <= 1'b1;
            end
            if (r_state == S_WB) begin
                r_retired <= r_retired + RET_ONE;
            end
        end
    end

    // All outputs decode from registered state only.
    assign imem_req = (r_state == S_FETCH);
    assign ir_load  = (r_state == S_DECODE);
    assign dmem_req = (r_state == S_MEM);
    assign dmem_we  = (r_state == S_MEM) & r_dmem_we;
    assign pc_we    = (r_state == S_WB);
    assign pc_sel   = (r_state == S_WB) & r_take_branch;
    assign rf_we    = (r_state == S_WB) & r_rf_we;
    assign busy     = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                      (r_state == S_EXECUTE) || (r_state == S_MEM) ||
                      (r_state == S_WB);
    assign err      = r_err;
    assign state    = r_state;
    assign retired  = r_retired;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Directed testbench for instr_cycle_sequencer; retired counter narrowed so wrap is reachable.
module tb_instr_cycle_sequencer;

    localparam int RW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          branch = 1'b0;
    logic          mem_rs = 1'b0;
    logic          mem_ws = 1'b0;
    logic          cntrl_rs = 1'b0;
    logic          alu_zero = 1'b0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, pc_sel, busy, err;
    logic [2:0]    state;
    logic [RW-1:0] retired;

    int n_checks = 0;
    int n_pass   = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    instr_cycle_sequencer #(.MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .run(run), .branch(branch), .mem_rs(mem_rs),
        .mem_ws(mem_ws), .cntrl_rs(cntrl_rs), .alu_zero(alu_zero),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_ack(dmem_ack), .ir_load(ir_load),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .busy(busy),
        .err(err), .state(state), .retired(retired)
    );

    always @(negedge clk) begin
        if (!rst && pc_we && (imem_req || dmem_req)) overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s got=0x%0h exp=0x%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: ack immediately, pass DECODE, land in EXECUTE.
    task automatic to_execute();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
    endtask

    function automatic logic [6:0] strobes();
        return {imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, pc_sel};
    endfunction

    initial begin
        int mc;
        int wbs;
        int cyc;

        tick();
        tick();
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_retired", 32'(retired), 0);
        check_eq("rst_strobes", 32'(strobes()), 0);
        rst = 1'b0;
        tick();
        check_eq("idle_hold", 32'(state), 0);

        // ALU op
        cntrl_rs = 1'b1;
        run = 1'b1;
        tick();
        check_eq("alu_fetch", 32'(state), 1);
        check_eq("alu_imem_req", 32'(imem_req), 1);
        check_eq("alu_busy", 32'(busy), 1);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check_eq("alu_decode", 32'(state), 2);
        check_eq("alu_ir_load", 32'(ir_load), 1);
        check_eq("alu_imem_drop", 32'(imem_req), 0);
        tick();
        check_eq("alu_exec", 32'(state), 3);
        check_eq("alu_ir_load_off", 32'(ir_load), 0);
        tick();
        check_eq("alu_wb", 32'(state), 5);
        check_eq("alu_wb_strobes", 32'(strobes()), 32'b0000110);
        check_eq("alu_ret_in_wb", 32'(retired), 0);
        tick();
        check_eq("alu_refetch", 32'(state), 1);
        check_eq("alu_strobes_off", 32'(strobes()), 32'b1000000);
        check_eq("alu_retired", 32'(retired), 1);

        // Load, ack in 3rd MEM cycle, run dropped during MEM
        mem_rs = 1'b1;
        to_execute();
        check_eq("ld_exec", 32'(state), 3);
        tick();
        check_eq("ld_mem1", 32'(state), 4);
        check_eq("ld_req_we", 32'({dmem_req, dmem_we}), 32'b10);
        run = 1'b0;
        tick();
        check_eq("ld_mem2", 32'(state), 4);
        tick();
        dmem_ack = 1'b1;
        check_eq("ld_mem3_req", 32'(dmem_req), 1);
        tick();
        dmem_ack = 1'b0;
        check_eq("ld_wb", 32'(state), 5);
        check_eq("ld_wb_strobes", 32'(strobes()), 32'b0000110);
        tick();
        check_eq("ld_idle", 32'(state), 0);
        check_eq("ld_idle_busy", 32'(busy), 0);
        check_eq("ld_retired", 32'(retired), 2);
        mem_rs = 1'b0;

        // Branch taken
        cntrl_rs = 1'b0;
        branch = 1'b1;
        alu_zero = 1'b1;
        run = 1'b1;
        tick();
        to_execute();
        run = 1'b0;
        tick();
        check_eq("bt_wb", 32'(state), 5);
        check_eq("bt_strobes", 32'(strobes()), 32'b0000011);
        tick();
        check_eq("bt_retired", 32'(retired), 3);

        // Branch not taken
        alu_zero = 1'b0;
        run = 1'b1;
        tick();
        to_execute();
        run = 1'b0;
        tick();
        check_eq("bnt_strobes", 32'(strobes()), 32'b0000010);
        tick();
        branch = 1'b0;

        // Store, ack on exactly the timeout cycle
        mem_ws = 1'b1;
        run = 1'b1;
        tick();
        to_execute();
        tick();
        check_eq("st_req_we", 32'({dmem_req, dmem_we}), 32'b11);
        run = 1'b0;
        repeat (TO - 1) tick();
        check_eq("st15_mem", 32'(state), 4);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check_eq("st15_wb", 32'(state), 5);
        check_eq("st15_noerr", 32'(err), 0);
        tick();
        check_eq("st15_idle", 32'(state), 0);
        check_eq("st15_retired", 32'(retired), 5);
        mem_ws = 1'b0;

        // Illegal mem_rs & mem_ws, then async reset mid-cycle
        mem_rs = 1'b1;
        mem_ws = 1'b1;
        run = 1'b1;
        tick();
        to_execute();
        check_eq("ill_exec", 32'(state), 3);
        tick();
        check_eq("ill_state", 32'(state), 6);
        check_eq("ill_err", 32'(err), 1);
        check_eq("ill_busy", 32'(busy), 0);
        repeat (3) tick();
        check_eq("ill_sticky", 32'({state, err}), 32'b1101);
        check_eq("ill_strobes", 32'(strobes()), 0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_state", 32'(state), 0);
        check_eq("arst_err", 32'(err), 0);
        check_eq("arst_retired", 32'(retired), 0);
        check_eq("arst_busy", 32'(busy), 0);
        mem_rs = 1'b0;
        mem_ws = 1'b0;
        tick();
        rst = 1'b0;

        // Store without ack -> timeout
        mem_ws = 1'b1;
        tick();
        to_execute();
        tick();
        mc = 0;
        while (state == 3'd4 && mc < 40) begin
            mc++;
            tick();
        end
        check_eq("to_mem_cycles", 32'(mc), TO);
        check_eq("to_state", 32'(state), 6);
        check_eq("to_err_req", 32'({err, dmem_req}), 32'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_ws = 1'b0;

        // Fetch without ack -> timeout
        tick();
        mc = 0;
        while (state == 3'd1 && mc < 40) begin
            mc++;
            tick();
        end
        check_eq("fto_cycles", 32'(mc), TO);
        check_eq("fto_state", 32'({state, err}), 32'b1101);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Retired counter wrap
        cntrl_rs = 1'b1;
        imem_ack = 1'b1;
        wbs = 0;
        cyc = 0;
        while (wbs < 256 && cyc < 3000) begin
            tick();
            cyc++;
            if (state == 3'd5) wbs++;
        end
        check_eq("wrap_wbs", 32'(wbs), 256);
        check_eq("wrap_pre", 32'(retired), 255);
        run = 1'b0;
        imem_ack = 1'b0;
        tick();
        check_eq("wrap_zero", 32'(retired), 0);
        check_eq("wrap_idle", 32'(state), 0);

        check_eq("no_pc_overlap", 32'(overlap), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
